// File: rtl/sequence_pattern_detector_param.sv
// Serial pattern detector with a loadable pattern, overlap control and a saturating match counter.
// detector_out is a registered Moore flag: high in the cycle after the edge that completes a match.
module sequence_pattern_detector_param #(
   parameter int unsigned PATTERN_WIDTH = 4,
   parameter logic [PATTERN_WIDTH-1:0] PATTERN_RESET = 4'b1011,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     sequence_valid,
   input  logic                     sequence_in,
   input  logic                     pattern_load,
   input  logic [PATTERN_WIDTH-1:0] pattern_in,
   input  logic                     overlap_en,
   input  logic                     count_clear,
   output logic                     detector_out,
   output logic [COUNT_WIDTH-1:0]   match_count
);

   localparam int unsigned FillWidth = $clog2(PATTERN_WIDTH + 1);
   localparam logic [FillWidth-1:0] FillMax = FillWidth'(PATTERN_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

   logic [PATTERN_WIDTH-1:0] pat_q, pat_d;
   logic [PATTERN_WIDTH-1:0] hist_q, hist_d;
   logic [FillWidth-1:0]     fill_q, fill_d;
   logic                     det_q, det_d;
   logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [PATTERN_WIDTH-1:0] hist_shift;
   logic [FillWidth-1:0]     fill_inc;
   logic                     match;

   always_comb begin
      hist_shift = {hist_q[PATTERN_WIDTH-2:0], sequence_in};
      fill_inc   = (fill_q == FillMax) ? FillMax : fill_q + 1'b1;
      match      = 1'b0;
      pat_d      = pat_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      det_d      = 1'b0;
      cnt_d      = cnt_q;

      // A load discards any bit presented on the same edge.
      if (pattern_load) begin
         pat_d  = pattern_in;
         fill_d = '0;
      end else if (sequence_valid) begin
         match  = (hist_shift == pat_q) && (fill_inc == FillMax);
         hist_d = hist_shift;
         fill_d = (match && !overlap_en) ? '0 : fill_inc;
         det_d  = match;
      end

      if (count_clear) begin
         cnt_d = match ? COUNT_WIDTH'(1) : '0;
      end else if (match && (cnt_q != CountMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pat_q  <= PATTERN_RESET;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
      end
   end

   assign detector_out = det_q;
   assign match_count  = cnt_q;

endmodule

// File: tb/tb_sequence_pattern_detector_param.sv
// Table-driven bench with a scoreboard queue; a second instance with a 2-bit counter
// shares the stimulus to exercise saturation.
module tb_sequence_pattern_detector_param;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       sequence_valid = 1'b0;
   logic       sequence_in = 1'b0;
   logic       pattern_load = 1'b0;
   logic [3:0] pattern_in = 4'b0000;
   logic       overlap_en = 1'b1;
   logic       count_clear = 1'b0;
   logic       det_a, det_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int tests = 0;
   int failed = 0;

   always #5 clock = ~clock;

   sequence_pattern_detector_param #(
      .PATTERN_WIDTH(4), .PATTERN_RESET(4'b1011), .COUNT_WIDTH(8)
   ) dut_a (
      .clock(clock), .reset(reset), .sequence_valid(sequence_valid),
      .sequence_in(sequence_in), .pattern_load(pattern_load), .pattern_in(pattern_in),
      .overlap_en(overlap_en), .count_clear(count_clear),
      .detector_out(det_a), .match_count(cnt_a)
   );

   sequence_pattern_detector_param #(
      .PATTERN_WIDTH(4), .PATTERN_RESET(4'b1011), .COUNT_WIDTH(2)
   ) dut_b (
      .clock(clock), .reset(reset), .sequence_valid(sequence_valid),
      .sequence_in(sequence_in), .pattern_load(pattern_load), .pattern_in(pattern_in),
      .overlap_en(overlap_en), .count_clear(count_clear),
      .detector_out(det_b), .match_count(cnt_b)
   );

   typedef struct {
      logic       v;
      logic       d;
      logic       ld;
      logic [3:0] pat;
      logic       ov;
      logic       clr;
      logic       det;
      int         cnt;
   } vec_t;

   typedef struct {
      logic det;
      int   cnt;
      int   idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic vec_t mk(logic v, logic d, logic ld, logic [3:0] pat, logic ov,
                               logic clr, logic det, int cnt);
      vec_t r;
      r.v = v; r.d = d; r.ld = ld; r.pat = pat; r.ov = ov; r.clr = clr;
      r.det = det; r.cnt = cnt;
      return r;
   endfunction

   task automatic check(string name, int idx, int act, int req);
      tests++;
      if (act != req) begin
         failed++;
         $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, req);
      end
   endtask

   task automatic check_all(string name, int idx, logic det, int cnt);
      int cnt2;
      cnt2 = (cnt > 3) ? 3 : cnt;
      check({name, " det_a"}, idx, int'(det_a), int'(det));
      check({name, " det_b"}, idx, int'(det_b), int'(det));
      check({name, " cnt_a"}, idx, int'(cnt_a), cnt);
      check({name, " cnt_b"}, idx, int'(cnt_b), cnt2);
   endtask

   task automatic step(vec_t t, int idx);
      exp_t e, got;
      @(negedge clock);
      sequence_valid = t.v;
      sequence_in    = t.d;
      pattern_load   = t.ld;
      pattern_in     = t.pat;
      overlap_en     = t.ov;
      count_clear    = t.clr;
      e.det = t.det; e.cnt = t.cnt; e.idx = idx;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard empty", idx, 0, 1);
      end else begin
         got = sb.pop_front();
         check_all("vec", got.idx, got.det, got.cnt);
      end
   endtask

   task automatic reset_pulse(string name, int idx);
      sequence_valid = 1'b0;
      pattern_load   = 1'b0;
      count_clear    = 1'b0;
      #2 reset = 1'b0;
      #1 check_all(name, idx, 1'b0, 0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      // Basic match, overlap, gap and load behaviour (pattern 1011 after reset)
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,0));
      tbl.push_back(mk(1,0,0,4'h0,1,0, 0,0));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,0));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,1));
      tbl.push_back(mk(0,0,0,4'h0,1,0, 0,1));
      tbl.push_back(mk(0,0,1,4'hB,1,0, 0,1));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,1));
      tbl.push_back(mk(1,0,0,4'h0,1,0, 0,1));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,1));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,2));
      tbl.push_back(mk(1,0,0,4'h0,1,0, 0,2));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,2));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,3));
      tbl.push_back(mk(0,0,1,4'hB,0,0, 0,3));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 0,3));
      tbl.push_back(mk(1,0,0,4'h0,0,0, 0,3));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 0,3));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 1,4));
      tbl.push_back(mk(1,0,0,4'h0,0,0, 0,4));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 0,4));
      tbl.push_back(mk(1,1,0,4'h0,0,0, 0,4));
      tbl.push_back(mk(0,0,1,4'hB,1,0, 0,4));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,4));
      tbl.push_back(mk(1,0,0,4'h0,1,0, 0,4));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,4'h0,1,0, 0,4));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,4));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,5));
      // Load 1111 with a concurrent valid bit that must be dropped
      tbl.push_back(mk(1,1,1,4'hF,1,0, 0,5));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,5));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,5));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,5));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,6));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,7));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,8));
      tbl.push_back(mk(1,1,1,4'hB,1,0, 0,8));
      // Clear, saturation of the 2-bit counter, clear on a matching edge
      tbl.push_back(mk(0,0,0,4'h0,1,1, 0,0));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,0));
      tbl.push_back(mk(1,0,0,4'h0,1,0, 0,0));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,0));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 1,1));
      for (int k = 2; k <= 5; k++) begin
         tbl.push_back(mk(1,0,0,4'h0,1,0, 0,k-1));
         tbl.push_back(mk(1,1,0,4'h0,1,0, 0,k-1));
         tbl.push_back(mk(1,1,0,4'h0,1,0, 1,k));
      end
      tbl.push_back(mk(1,0,0,4'h0,1,0, 0,5));
      tbl.push_back(mk(1,1,0,4'h0,1,0, 0,5));
      tbl.push_back(mk(1,1,0,4'h0,1,1, 1,1));

      #3;
      check_all("reset state", 0, 1'b0, 0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // Reset mid-match: outputs drop at once, pattern returns to 1011
      step(mk(0,0,1,4'hF,1,0, 0,1), 100);
      step(mk(1,1,0,4'h0,1,0, 0,1), 101);
      step(mk(1,1,0,4'h0,1,0, 0,1), 102);
      step(mk(1,1,0,4'h0,1,0, 0,1), 103);
      step(mk(1,1,0,4'h0,1,0, 1,2), 104);
      reset_pulse("async reset", 105);
      step(mk(1,1,0,4'h0,1,0, 0,0), 106);
      step(mk(1,0,0,4'h0,1,0, 0,0), 107);
      step(mk(1,1,0,4'h0,1,0, 0,0), 108);
      reset_pulse("partial reset", 109);
      step(mk(1,1,0,4'h0,1,0, 0,0), 110);
      step(mk(1,0,0,4'h0,1,0, 0,0), 111);
      step(mk(1,1,0,4'h0,1,0, 0,0), 112);
      step(mk(1,1,0,4'h0,1,0, 1,1), 113);
      step(mk(0,0,0,4'h0,1,0, 0,1), 114);

      if (sb.size() != 0) check("scoreboard leftover", 999, sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
